// File: rtl/checker_pkg.sv
// Shared types and constants for the checkers player-input front end.
package checker_pkg;

  typedef enum logic [1:0] {
    PH_PICK   = 2'd0,
    PH_WAIT   = 2'd1,
    PH_DEST   = 2'd2,
    PH_COMMIT = 2'd3
  } phase_e;

  localparam int KEY_X       = 0;
  localparam int KEY_Y       = 1;
  localparam int KEY_CONFIRM = 2;
  localparam int KEY_CANCEL  = 3;
  localparam int NUM_KEYS    = 4;

  localparam int SLOT_W         = 7;
  localparam int SLOT_VALID_BIT = 6;
  localparam int NUM_SLOTS      = 4;

  typedef logic [5:0] loc_t;

  function automatic logic [SLOT_W-1:0] slot_of(input logic [NUM_SLOTS*SLOT_W-1:0] lm,
                                                input int k);
    return lm[k*SLOT_W +: SLOT_W];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, stability counter, registered press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has disagreed with the current one long enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchronizer, debounce state and falling-edge pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= CNT_ZERO;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= key_n_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_dly_q & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/board_cursor_ctrl.sv
// Player input front end: debounced keys, board cursor and pick/destination
// selection FSM that issues a move request against the legal-move bus.
module board_cursor_ctrl
  import checker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LEGAL_WAIT      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_n,
  input  logic [NUM_SLOTS*SLOT_W-1:0] legal_move,
  output logic [5:0]                  cursor_loc,
  output logic [5:0]                  select_loc,
  output logic                        move_req,
  output logic [5:0]                  move_from,
  output logic [5:0]                  move_to,
  output logic                        sel_err,
  output logic [1:0]                  phase
);

  localparam int WAIT_W = (LEGAL_WAIT > 1) ? $clog2(LEGAL_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LEGAL_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  logic [NUM_KEYS-1:0] press_s;
  logic                ev_cancel_s, ev_confirm_s, ev_x_s, ev_y_s;
  logic                any_valid_s, hit_s;
  logic [SLOT_W-1:0]   slot_s;

  phase_e              phase_q;
  loc_t                cursor_q, select_q, from_q, to_q;
  logic                move_req_q, sel_err_q;
  logic [WAIT_W-1:0]   wait_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk     (clk),
      .rst     (rst),
      .key_n_i (key_n[k]),
      .press_o (press_s[k])
    );
  end

  // Same-cycle key events: cancel beats confirm beats x beats y.
  always_comb begin
    ev_cancel_s  = press_s[KEY_CANCEL];
    ev_confirm_s = press_s[KEY_CONFIRM] & ~press_s[KEY_CANCEL];
    ev_x_s       = press_s[KEY_X] & ~press_s[KEY_CANCEL] & ~press_s[KEY_CONFIRM];
    ev_y_s       = press_s[KEY_Y] & ~press_s[KEY_CANCEL] & ~press_s[KEY_CONFIRM]
                   & ~press_s[KEY_X];
  end

  // Live view of the legal-move bus: any valid slot, and a valid slot at the cursor.
  always_comb begin
    any_valid_s = 1'b0;
    hit_s       = 1'b0;
    slot_s      = {SLOT_W{1'b0}};
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_s      = slot_of(legal_move, k);
      any_valid_s = any_valid_s | slot_s[SLOT_VALID_BIT];
      hit_s       = hit_s | (slot_s[SLOT_VALID_BIT] & (slot_s[5:0] == cursor_q));
    end
  end

  // Selection FSM with cursor counters and registered request/error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= PH_PICK;
      cursor_q   <= 6'd0;
      select_q   <= 6'd0;
      from_q     <= 6'd0;
      to_q       <= 6'd0;
      move_req_q <= 1'b0;
      sel_err_q  <= 1'b0;
      wait_q     <= WAIT_ZERO;
    end else begin
      move_req_q <= 1'b0;
      sel_err_q  <= 1'b0;
      case (phase_q)
        PH_PICK: begin
          if (ev_confirm_s) begin
            select_q <= cursor_q;
            wait_q   <= WAIT_LOAD;
            phase_q  <= PH_WAIT;
          end else if (ev_x_s) begin
            cursor_q[5:3] <= cursor_q[5:3] + 3'd1;
          end else if (ev_y_s) begin
            cursor_q[2:0] <= cursor_q[2:0] + 3'd1;
          end
        end
        PH_WAIT: begin
          if (ev_cancel_s) begin
            phase_q <= PH_PICK;
          end else if (wait_q == WAIT_ZERO) begin
            if (any_valid_s) begin
              phase_q <= PH_DEST;
            end else begin
              sel_err_q <= 1'b1;
              phase_q   <= PH_PICK;
            end
          end else begin
            wait_q <= wait_q - WAIT_ONE;
          end
        end
        PH_DEST: begin
          if (ev_cancel_s) begin
            phase_q <= PH_PICK;
          end else if (ev_confirm_s) begin
            if (hit_s) begin
              // A hit means the matched target equals the cursor.
              move_req_q <= 1'b1;
              from_q     <= select_q;
              to_q       <= cursor_q;
              phase_q    <= PH_COMMIT;
            end else begin
              sel_err_q <= 1'b1;
            end
          end else if (ev_x_s) begin
            cursor_q[5:3] <= cursor_q[5:3] + 3'd1;
          end else if (ev_y_s) begin
            cursor_q[2:0] <= cursor_q[2:0] + 3'd1;
          end
        end
        PH_COMMIT: begin
          phase_q <= PH_PICK;
        end
        default: begin
          phase_q <= PH_PICK;
        end
      endcase
    end
  end

  assign cursor_loc = cursor_q;
  assign select_loc = select_q;
  assign move_req   = move_req_q;
  assign move_from  = from_q;
  assign move_to    = to_q;
  assign sel_err    = sel_err_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Self-checking bench for board_cursor_ctrl: directed scenarios plus random key
// sequences checked against an event-level model of the selection rules.
module tb_board_cursor_ctrl;

  localparam int D  = 4;
  localparam int LW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_n;
  logic [27:0] legal_move;
  logic [5:0]  cursor_loc, select_loc, move_from, move_to;
  logic        move_req, sel_err;
  logic [1:0]  phase;

  int checks = 0;
  int errors = 0;

  // Output monitor state
  int         err_seen = 0, req_seen = 0, both_seen = 0;
  logic [1:0] cap_phase = 2'd0;
  int         wait_run = 0, last_wait_len = 0;

  // Event-level reference model
  int m_x = 0, m_y = 0, m_sel = 0, m_phase = 0, m_from = 0, m_to = 0;
  int m_err = 0, m_req = 0;

  board_cursor_ctrl #(.DEBOUNCE_CYCLES(D), .LEGAL_WAIT(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .legal_move (legal_move),
    .cursor_loc (cursor_loc),
    .select_loc (select_loc),
    .move_req   (move_req),
    .move_from  (move_from),
    .move_to    (move_to),
    .sel_err    (sel_err),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (sel_err === 1'b1) err_seen++;
      if (move_req === 1'b1) begin
        req_seen++;
        cap_phase = phase;
      end
      if (sel_err === 1'b1 && move_req === 1'b1) both_seen++;
      if (phase === 2'd1) wait_run++;
      else begin
        if (wait_run != 0) last_wait_len = wait_run;
        wait_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lm_valid(input logic [27:0] lm, input int k);
    logic [27:0] t;
    t = lm >> (7 * k);
    return t[6];
  endfunction

  function automatic int lm_target(input logic [27:0] lm, input int k);
    logic [27:0] t;
    t = lm >> (7 * k);
    return int'(t[5:0]);
  endfunction

  task automatic model_event(input logic [3:0] mask, input logic [27:0] lm);
    int  t;
    int  cur;
    bit  any, found;
    if (mask[3]) t = 3;
    else if (mask[2]) t = 2;
    else if (mask[0]) t = 0;
    else if (mask[1]) t = 1;
    else t = -1;
    cur   = m_x * 8 + m_y;
    any   = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (lm_valid(lm, k)) begin
        any = 1'b1;
        if (lm_target(lm, k) == cur) found = 1'b1;
      end
    end
    if (m_phase == 0) begin
      if (t == 2) begin
        m_sel = cur;
        if (any) m_phase = 2;
        else m_err++;
      end else if (t == 0) m_x = (m_x + 1) % 8;
      else if (t == 1) m_y = (m_y + 1) % 8;
    end else if (m_phase == 2) begin
      if (t == 3) m_phase = 0;
      else if (t == 2) begin
        if (found) begin
          m_req++;
          m_from  = m_sel;
          m_to    = cur;
          m_phase = 0;
        end else m_err++;
      end else if (t == 0) m_x = (m_x + 1) % 8;
      else if (t == 1) m_y = (m_y + 1) % 8;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".phase"},  32'(phase),      32'(m_phase));
    chk({tag, ".cursor"}, 32'(cursor_loc), 32'(m_x * 8 + m_y));
    chk({tag, ".select"}, 32'(select_loc), 32'(m_sel));
    chk({tag, ".from"},   32'(move_from),  32'(m_from));
    chk({tag, ".to"},     32'(move_to),    32'(m_to));
    chk({tag, ".errs"},   32'(err_seen),   32'(m_err));
    chk({tag, ".reqs"},   32'(req_seen),   32'(m_req));
  endtask

  // Hold the masked keys low long enough to register, then release and settle.
  task automatic press(input logic [3:0] mask, input bit glitch, input string tag);
    if (glitch) begin
      key_n = ~mask;
      repeat ($urandom_range(1, D - 1)) @(negedge clk);
      key_n = 4'hF;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    key_n = ~mask;
    repeat (D + 8) @(negedge clk);
    key_n = 4'hF;
    repeat (D + 8) @(negedge clk);
    model_event(mask, legal_move);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_sel = 0; m_phase = 0; m_from = 0; m_to = 0;
  endtask

  function automatic logic [27:0] rand_legal(input bit allow_empty);
    logic [27:0] lm;
    logic [6:0]  s;
    lm = 28'd0;
    if (allow_empty && $urandom_range(0, 3) == 0) return lm;
    for (int k = 0; k < 4; k++) begin
      s[6]   = 1'($urandom_range(0, 1));
      s[5:0] = ($urandom_range(0, 2) == 0) ? 6'(m_x * 8 + m_y) : 6'($urandom_range(0, 63));
      lm     = lm | (28'(s) << (7 * k));
    end
    return lm;
  endfunction

  initial begin
    logic [3:0] mask;
    int         r;

    rst        = 1'b0;
    key_n      = 4'hF;
    legal_move = 28'd0;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.move_req", 32'(move_req), 32'd0);
    chk("reset.sel_err",  32'(sel_err),  32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Debounce: 3-cycle glitch, 1 high, then a real press; event lands in cycle D+3.
    key_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    key_n[0] = 1'b1;
    @(negedge clk);
    key_n[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("debounce.c%0d", i + 1), 32'(cursor_loc), (i + 1 >= D + 4) ? 32'h08 : 32'h00);
    end
    key_n = 4'hF;
    repeat (D + 8) @(negedge clk);
    m_x = 1;
    check_all("debounce");

    // Cursor wrap in x, then y from 0.
    for (int i = 0; i < 7; i++) press(4'b0001, 1'b0, "wrap_x_a");
    chk("wrap_x_home", 32'(cursor_loc), 32'h00);
    for (int i = 0; i < 8; i++) press(4'b0001, 1'b0, "wrap_x_b");
    chk("wrap_x_full", 32'(cursor_loc), 32'h00);
    for (int i = 0; i < 7; i++) press(4'b0010, 1'b0, "wrap_y");
    chk("wrap_y_end", 32'(cursor_loc), 32'h07);

    // Successful move 0x09 -> 0x12 with slot1 = {1, 0x12}.
    press(4'b0001, 1'b0, "to09_x");
    press(4'b0010, 1'b0, "to09_y1");
    press(4'b0010, 1'b0, "to09_y2");
    chk("at09", 32'(cursor_loc), 32'h09);
    legal_move = 28'h0002900;
    press(4'b0100, 1'b0, "succ_pick");
    chk("succ_wait_len", 32'(last_wait_len), 32'(LW));
    chk("succ_in_dest", 32'(phase), 32'd2);
    press(4'b0001, 1'b0, "succ_x");
    press(4'b0010, 1'b0, "succ_y");
    press(4'b0100, 1'b0, "succ_commit");
    chk("succ_from", 32'(move_from), 32'h09);
    chk("succ_to", 32'(move_to), 32'h12);
    chk("succ_commit_phase", 32'(cap_phase), 32'd3);

    // Empty selection.
    legal_move = 28'd0;
    press(4'b0100, 1'b0, "empty");

    // DEST mismatch, cancel, and cancel+confirm together.
    legal_move = 28'h0000040;
    press(4'b0100, 1'b0, "mis_pick");
    press(4'b0001, 1'b0, "mis_x");
    press(4'b0010, 1'b0, "mis_y");
    chk("mis_at1b", 32'(cursor_loc), 32'h1B);
    press(4'b0100, 1'b0, "mis_confirm");
    chk("mis_stay_dest", 32'(phase), 32'd2);
    press(4'b1000, 1'b0, "mis_cancel");
    press(4'b0100, 1'b0, "mis_pick2");
    press(4'b1100, 1'b0, "cancel_wins");
    chk("cancel_wins_pick", 32'(phase), 32'd0);

    // Reset during WAIT.
    legal_move = 28'h0000040;
    key_n[2]   = 1'b0;
    for (int i = 0; i < 40 && phase !== 2'd1; i++) @(negedge clk);
    chk("rst_in_wait", 32'(phase), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst.cursor", 32'(cursor_loc), 32'd0);
    chk("rst.select", 32'(select_loc), 32'd0);
    chk("rst.from", 32'(move_from), 32'd0);
    chk("rst.to", 32'(move_to), 32'd0);
    chk("rst.req", 32'(move_req), 32'd0);
    chk("rst.err", 32'(sel_err), 32'd0);
    chk("rst.phase", 32'(phase), 32'd0);
    key_n = 4'hF;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    legal_move = 28'd0;
    press(4'b0100, 1'b0, "post_rst");

    // Random key sequences with occasional glitches.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: mask = 4'b0001;
        3, 4:    mask = 4'b0010;
        5, 6:    mask = 4'b0100;
        7:       mask = 4'b1000;
        8:       mask = 4'($urandom_range(1, 15));
        default: mask = 4'b1100;
      endcase
      legal_move = rand_legal(m_phase == 0);
      press(mask, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    chk("never_both", 32'(both_seen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_cursor_ctrl.md
# board_cursor_ctrl

Player input front end for the checkers design. Debounces four push buttons, moves a board cursor, and runs a pick/destination selection FSM. It drives `select_loc` into the board/legal-move stage and reads back that stage's registered `legal_move` bus. It emits a one-cycle move request `{move_from, move_to}` only when the chosen destination matches a valid legal-move slot.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz).
- `LEGAL_WAIT`, default 2: cycles from a `select_loc` update until `legal_move` is valid.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `key_n`  in  4: raw buttons, active-low, asynchronous to `clk`.
  - [0] = cursor x+1
  - [1] = cursor y+1
  - [2] = confirm
  - [3] = cancel
- `legal_move`  in  28: four 7-bit slots. Slot k is bits [7k+6:7k]: bit 7k+6 = valid, bits [7k+5:7k] = `{x,y}` target.
- `cursor_loc`  out  6: current cursor, `{x[5:3], y[2:0]}`.
- `select_loc`  out  6: held source square, fed to the legal-move stage.
- `move_req`  out  1: one-cycle pulse; `move_from`/`move_to` are valid with it.
- `move_from`  out  6: source square of the committed move.
- `move_to`  out  6: destination square of the committed move.
- `sel_err`  out  1: one-cycle pulse on a rejected confirm.
- `phase`  out  2: FSM state, for display highlighting.

## Operation
- Per key:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level flips after the synced level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce clears the counter.
  - Press event = debounced 1→0 transition, registered as a one-cycle pulse. Releases generate no event.
- Same-cycle events resolve by priority: cancel > confirm > x > y. Lower-priority events that cycle are discarded.
- Cursor x/y are 3-bit counters. +1 wraps 7→0. x and y are independent.
- FSM states (`phase` encoding):
  - PICK (0):
    - x/y events move the cursor.
    - confirm → `select_loc` <= `cursor_loc`; load wait counter; go to WAIT.
    - cancel → no effect.
  - WAIT (1):
    - Counts `LEGAL_WAIT` cycles; cursor events are ignored.
    - At expiry, if any slot valid bit (6, 13, 20, 27) is set → DEST.
    - Otherwise `sel_err` pulses and the FSM returns to PICK.
    - cancel → PICK immediately.
  - DEST (2):
    - x/y events move the cursor.
    - confirm: if `cursor_loc` equals the target of any valid slot → COMMIT. Otherwise pulse `sel_err` and stay in DEST.
    - cancel → PICK; cursor is not moved.
  - COMMIT (3):
    - One cycle: `move_req`=1, `move_from`=`select_loc`, `move_to`=matched target → PICK.
- `legal_move` is sampled combinationally on the DEST confirm cycle. No copy is latched.
- `select_loc` holds its value through PICK, so the legal-move stage keeps showing the last selection.
- `move_from`/`move_to` hold their last values after the pulse.

## Timing
- Reset values:
  - `cursor_loc`=0, `select_loc`=0, `move_from`=0, `move_to`=0
  - `move_req`=0, `sel_err`=0
  - `phase`=PICK
  - debounced levels=1 (released), debounce counters=0
- Reset mid-operation abandons any selection; no `move_req` is emitted.
- Press latency: with `key_n` held low from cycle 0, the event pulse is high in cycle `DEBOUNCE_CYCLES`+3. This comprises 2 synchronizer cycles, `DEBOUNCE_CYCLES` of counting, and 1 edge register.
- Cursor, `select_loc` and `phase` update on the cycle after the event pulse.
- PICK confirm to DEST entry: `LEGAL_WAIT`+1 cycles.
- DEST confirm to `move_req` high: the next cycle, in COMMIT.
- PICK is re-entered 1 cycle after that.
- `sel_err` and `move_req` are never high in the same cycle.

## Structure
- Package `checker_pkg` holds:
  - the `phase` enum
  - key index constants
  - the slot width (7) and valid-bit offset (6)
  - the slot count (4)
  - `loc_t` as a 6-bit `{x,y}` type
- Sub-module `key_debounce`, parameterized by `DEBOUNCE_CYCLES`, contains the synchronizer, counter and press pulse. It is instantiated four times.
- The top level holds the priority resolver, the cursor counters, the FSM and the slot-match compare.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4 and `LEGAL_WAIT`=2.
- Press debounce:
  - `key_n[0]` low for 3 cycles, high, then low for 10 cycles → exactly one x event, in cycle 7 of the second press.
  - Expected response: `cursor_loc` 0→8; no event from the first glitch.
- Cursor wrap: eight x presses → `cursor_loc` x returns to 0 (0x08, …, 0x38, 0x00). Seven y presses from 0 → `cursor_loc`=0x07.
- Successful move:
  - Cursor at 0x09, confirm; drive `legal_move` slot1 = {1, 0x12} by the WAIT expiry.
  - Move to 0x12, confirm.
  - Expected response: one-cycle `move_req` with `move_from`=0x09 and `move_to`=0x12, then `phase`=PICK.
- Empty selection: confirm with `legal_move`=0 → `sel_err` pulses at WAIT expiry and `phase` returns to 0; `move_req` never asserts.
- DEST mismatch and cancel:
  - In DEST with only slot0 valid = {1, 0x00}, confirm at 0x1B → `sel_err` pulses and the FSM stays in DEST.
  - cancel → PICK with no `move_req`.
  - Simultaneous cancel+confirm in DEST → cancel wins.
- Reset mid-operation: assert `rst`=0 during WAIT → all outputs are at reset values asynchronously; after release a confirm starts from `cursor_loc`=0.
